// File: rtl/maxnet_pkg.sv
// Shared types, constants and float helpers for the Maxnet iteration scheduler.
//   state_t      : scheduler FSM states
//   fpu_req_t    : FMA request payload (a*b+c)
//   fp_is_zero   : true when magnitude bits are all zero (+0 or -0)
//   fp_relu      : negative values become +0
//   term_index   : bank index of the j-th inhibition term for neuron i
package maxnet_pkg;

    localparam int unsigned N_NEURON = 4;
    localparam int unsigned FP_W     = 32;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned FP_SIGN  = 31;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

    typedef logic [FP_W-1:0] fp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_COMMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        fp_t a;
        fp_t b;
        fp_t c;
    } fpu_req_t;

    function automatic logic fp_is_zero(input fp_t x);
        return (x[FP_SIGN-1:0] == '0);
    endfunction

    function automatic fp_t fp_relu(input fp_t x);
        return x[FP_SIGN] ? FP_ZERO : x;
    endfunction

    // Terms skip the neuron's own index, in ascending order.
    function automatic logic [IDX_W-1:0] term_index(input logic [IDX_W-1:0] i,
                                                    input logic [IDX_W-1:0] j);
        return (j < i) ? j : IDX_W'(j + 2'd1);
    endfunction

endpackage

// File: rtl/maxnet_sched_if.sv
// Request/response link between the Maxnet scheduler and the shared FMA unit.
//   fpu_valid/fpu_ready    : request handshake, operands fpu_a*fpu_b+fpu_c
//   fpu_res_valid/fpu_res  : one-cycle result strobe and value
//   fpu_ovf                : overflow flag qualified by fpu_res_valid
// master = scheduler side, slave = FMA side.
interface maxnet_sched_if;
    import maxnet_pkg::*;

    logic fpu_valid;
    logic fpu_ready;
    fp_t  fpu_a;
    fp_t  fpu_b;
    fp_t  fpu_c;
    logic fpu_res_valid;
    fp_t  fpu_res;
    logic fpu_ovf;

    modport master (
        output fpu_valid, fpu_a, fpu_b, fpu_c,
        input  fpu_ready, fpu_res_valid, fpu_res, fpu_ovf
    );

    modport slave (
        input  fpu_valid, fpu_a, fpu_b, fpu_c,
        output fpu_ready, fpu_res_valid, fpu_res, fpu_ovf
    );

endinterface

// File: rtl/maxnet_winner_sel.sv
// Combinational survey of the activation bank.
//   i_bank    : 4 activations (already ReLU'd)
//   o_count   : number of nonzero entries
//   o_idx     : index of the lowest nonzero entry, 0 if none
//   o_val     : value of that entry, 0 if none
module maxnet_winner_sel
    import maxnet_pkg::*;
(
    input  fp_t [N_NEURON-1:0] i_bank,
    output logic [CNT_W-1:0]   o_count,
    output logic [IDX_W-1:0]   o_idx,
    output fp_t                o_val
);

    logic w_found;

    always_comb begin
        o_count = '0;
        o_idx   = '0;
        o_val   = FP_ZERO;
        w_found = 1'b0;
        for (int k = 0; k < N_NEURON; k++) begin
            if (!fp_is_zero(i_bank[k])) begin
                o_count = o_count + CNT_W'(1);
                if (!w_found) begin
                    w_found = 1'b1;
                    o_idx   = IDX_W'(k);
                    o_val   = i_bank[k];
                end
            end
        end
    end

endmodule

// File: rtl/maxnet_sched.sv
// Maxnet winner-take-all iteration scheduler. Holds the activation bank and
// drives one shared FMA unit until at most one activation remains nonzero.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin operation (accepted in IDLE/DONE)
//   eps, a1..a4            : inhibition weight and initial activations
//   finish                 : operation complete, held until next start
//   overflow, timeout      : abort reasons, valid with finish
//   out, winner            : winning activation and its index
//   fpu                    : FMA request/response link (master side)
module maxnet_sched
    import maxnet_pkg::*;
#(
    parameter int unsigned MAX_ITER = 64,
    parameter int unsigned ITER_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  fp_t              eps,
    input  fp_t              a1,
    input  fp_t              a2,
    input  fp_t              a3,
    input  fp_t              a4,
    output logic             finish,
    output logic             overflow,
    output logic             timeout,
    output fp_t              out,
    output logic [IDX_W-1:0] winner,
    maxnet_sched_if.master   fpu
);

    localparam logic [IDX_W-1:0] TERM_LAST = IDX_W'(N_NEURON - 2);
    localparam logic [IDX_W-1:0] NEUR_LAST = IDX_W'(N_NEURON - 1);

    state_t              r_state;
    state_t              w_state_nx;
    fp_t [N_NEURON-1:0]  r_bank;
    fp_t [N_NEURON-1:0]  r_shadow;
    fp_t                 r_eps;
    fpu_req_t            r_req;
    logic                r_valid;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [ITER_W-1:0]   r_iter;
    logic                r_finish;
    logic                r_overflow;
    logic                r_timeout;
    fp_t                 r_out;
    logic [IDX_W-1:0]    r_winner;

    logic [IDX_W-1:0]    w_nx_i;
    logic [IDX_W-1:0]    w_nx_j;
    logic [IDX_W-1:0]    w_nx_m;
    fp_t                 w_nx_c;
    logic [CNT_W-1:0]    w_nz_cnt;
    logic [IDX_W-1:0]    w_win_idx;
    fp_t                 w_win_val;
    logic                w_issue_load;

    maxnet_winner_sel u_winner_sel (
        .i_bank  (r_bank),
        .o_count (w_nz_cnt),
        .o_idx   (w_win_idx),
        .o_val   (w_win_val)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state plus the neuron/term/accumulator for the next request.
    always_comb begin
        w_state_nx = r_state;
        w_nx_i     = r_i;
        w_nx_j     = r_j;
        w_nx_c     = r_req.c;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nx = S_LOAD;
            end
            S_LOAD: w_state_nx = S_CHECK;
            S_CHECK: begin
                if ((w_nz_cnt <= CNT_W'(1)) || (r_iter == ITER_W'(MAX_ITER))) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_ISSUE;
                    w_nx_i     = '0;
                    w_nx_j     = '0;
                    w_nx_c     = r_bank[0];
                end
            end
            S_ISSUE: begin
                if (fpu.fpu_ready) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (fpu.fpu_res_valid) begin
                    if (fpu.fpu_ovf) begin
                        w_state_nx = S_DONE;
                    end else if (r_j != TERM_LAST) begin
                        w_state_nx = S_ISSUE;
                        w_nx_j     = r_j + 2'd1;
                        w_nx_c     = fpu.fpu_res;
                    end else if (r_i == NEUR_LAST) begin
                        w_state_nx = S_COMMIT;
                    end else begin
                        // Next neuron starts its accumulator from its own bank value.
                        w_state_nx = S_ISSUE;
                        w_nx_i     = r_i + 2'd1;
                        w_nx_j     = '0;
                        w_nx_c     = r_bank[r_i + 2'd1];
                    end
                end
            end
            S_COMMIT: w_state_nx = S_CHECK;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    assign w_nx_m       = term_index(w_nx_i, w_nx_j);
    assign w_issue_load = (w_state_nx == S_ISSUE) && (r_state != S_ISSUE);

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank     <= '0;
            r_shadow   <= '0;
            r_eps      <= FP_ZERO;
            r_req      <= '0;
            r_valid    <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_iter     <= '0;
            r_finish   <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_out      <= FP_ZERO;
            r_winner   <= '0;
        end else begin
            r_valid <= (w_state_nx == S_ISSUE);

            // Operands are frozen for the whole ISSUE stay.
            if (w_issue_load) begin
                r_req <= '{a: r_eps, b: r_bank[w_nx_m], c: w_nx_c};
                r_i   <= w_nx_i;
                r_j   <= w_nx_j;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_finish   <= 1'b0;
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_out      <= FP_ZERO;
                        r_winner   <= '0;
                    end
                end
                S_LOAD: begin
                    r_bank[0] <= fp_relu(a1);
                    r_bank[1] <= fp_relu(a2);
                    r_bank[2] <= fp_relu(a3);
                    r_bank[3] <= fp_relu(a4);
                    r_eps     <= eps;
                    r_iter    <= '0;
                end
                S_CHECK: begin
                    if (w_state_nx == S_DONE) begin
                        r_finish <= 1'b1;
                        if (w_nz_cnt <= CNT_W'(1)) begin
                            r_out    <= w_win_val;
                            r_winner <= w_win_idx;
                        end else begin
                            r_timeout <= 1'b1;
                            r_out     <= FP_ZERO;
                            r_winner  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (fpu.fpu_res_valid) begin
                        if (fpu.fpu_ovf) begin
                            r_finish   <= 1'b1;
                            r_overflow <= 1'b1;
                            r_out      <= FP_ZERO;
                            r_winner   <= '0;
                        end else if (r_j == TERM_LAST) begin
                            r_shadow[r_i] <= fp_relu(fpu.fpu_res);
                        end
                    end
                end
                S_COMMIT: begin
                    r_bank <= r_shadow;
                    r_iter <= r_iter + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign finish        = r_finish;
    assign overflow      = r_overflow;
    assign timeout       = r_timeout;
    assign out           = r_out;
    assign winner        = r_winner;
    assign fpu.fpu_valid = r_valid;
    assign fpu.fpu_a     = r_req.a;
    assign fpu.fpu_b     = r_req.b;
    assign fpu.fpu_c     = r_req.c;

endmodule
